fu_issue_queue: RTL
===================

Name: fu_issue_queue

Overview:
- Data-capturing issue queue directly upstream of one functional unit; drives the controller side of the FU interface.
- Accepts dispatched instructions from rename, holds them until all source operands hold values, then issues the oldest ready entry to the FU when the FU signals ready.
- Source operands still waiting are captured from the writeback broadcast bus.

Parameters:
- INST_ID_BITS, 6, instruction ID width
- PRN_BITS, 6, physical register number width
- MAX_OPERANDS, 3, source operand / destination PRN slots per instruction
- DEPTH, 8, queue entries (2..32)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- flush  input  1  discard all entries
- disp_valid  input  1  dispatch request
- disp_ready  output  1  queue can accept a dispatch
- disp_inst_id  input  INST_ID_BITS  instruction ID
- disp_inst  input  32  instruction word
- disp_pc  input  64  program counter
- disp_src_prn  input  [MAX_OPERANDS][PRN_BITS]  source PRNs
- disp_src_rdy  input  [MAX_OPERANDS]  source value already present (unused slots tied 1)
- disp_src_data  input  [MAX_OPERANDS][64]  source values, valid where disp_src_rdy=1
- disp_out_prn  input  [MAX_OPERANDS][PRN_BITS]  destination PRNs, passed through unchanged
- wb_valid  input  1  writeback broadcast valid
- wb_prn  input  PRN_BITS  broadcast PRN
- wb_data  input  64  broadcast value
- fu_ready  input  1  FU accepts an instruction this cycle
- inst_valid  output  1  issue strobe to FU
- inst_id  output  INST_ID_BITS  issued instruction ID
- inst  output  32  issued instruction word
- pc  output  64  issued PC
- op  output  [MAX_OPERANDS][64]  issued operand values
- out_prn  output  [MAX_OPERANDS][PRN_BITS]  issued destination PRNs
- count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, rst=1): all entries invalid; count=0; disp_ready=1; inst_valid=0; payload outputs 0.
- Storage: collapsing queue; index 0 is oldest. Entry = valid, inst_id, inst, pc, per-slot rdy/prn/data, out_prn.
- Dispatch: accepted when disp_valid && disp_ready. disp_ready = (count < DEPTH) && !flush; it does not depend on same-cycle issue (no comb path from fu_ready). New entry is written behind all surviving entries after any same-cycle collapse.
- Wakeup: when wb_valid, every valid entry slot with rdy=0 and prn==wb_prn sets rdy=1 and data=wb_data at the clock edge. A same-cycle dispatch with matching non-ready slot also captures wb_data.
- Ready entry: valid and all MAX_OPERANDS rdy bits set, using registered state only.
- Issue: combinational. inst_valid = fu_ready && (any ready entry). Payload comes from the lowest-index ready entry. When inst_valid=1 that entry is removed at the edge; younger entries shift down one index.
- Latency: dispatch with all sources ready at edge N is issuable in cycle N+1. Wakeup at edge N makes the entry issuable in cycle N+1.
- Simultaneous dispatch + issue with count==DEPTH: dispatch refused (disp_ready=0). count next = count + accept − issue.
- Flush: synchronous. At the edge all entries are invalidated and dispatch is ignored. inst_valid is forced 0 during the flush cycle. Async reset mid-operation drops everything immediately.
- Duplicate wb_prn matches across entries or slots all capture.

Optional Feature:
- FU_IQ_WAKEUP_BYPASS_EN.
- Defined: an entry counts as ready in the current cycle if every non-ready slot matches wb_prn with wb_valid=1. Such slots issue with wb_data on op, giving back-to-back wakeup-issue (latency 0 after broadcast).
- Undefined: readiness uses registered rdy only, as above.

Test Plan:
- Reset, then dispatch id=5 with all rdy=1, ops 0x11/0x22/0x33, fu_ready=1 -> next cycle inst_valid=1, inst_id=5, op={0x11,0x22,0x33}, count returns to 0.
- Dispatch id=1 waiting on prn 9, then id=2 all ready -> id=2 issues first. wb prn 9 data 0xABCD -> id=1 issues the next cycle with op[0]=0xABCD.
- Fill DEPTH=8 entries with fu_ready=0 -> disp_ready=0 and count=8. Raise fu_ready -> issues in dispatch order, one per cycle, disp_ready=1 after the first issue edge.
- Dispatch with slot prn 4 non-ready in the same cycle as wb prn 4 data 0x7 -> entry ready next cycle with op=0x7.
- Flush with 5 entries, concurrent disp_valid -> count=0 and inst_valid=0 next cycle, dispatched instruction dropped. Assert rst mid-issue -> outputs 0 immediately.
- With FU_IQ_WAKEUP_BYPASS_EN: entry waiting on prn 3, wb prn 3 data 0x55, fu_ready=1 -> inst_valid the same cycle with op=0x55. Without the macro -> issue one cycle later.

Source files
------------

// File: rtl/fu_issue_queue.sv
// fu_issue_queue: collapsing, data-capturing issue queue feeding one FU. Build with FU_IQ_WAKEUP_BYPASS_EN to issue on the broadcast cycle.
// Latency: dispatch or wakeup at edge N is issuable in cycle N+1 (same cycle with bypass). Backpressure: disp_ready = !full && !flush; issue is gated by fu_ready.
module fu_issue_queue #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int DEPTH        = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        flush,
  input  logic                                        disp_valid,
  output logic                                        disp_ready,
  input  logic [INST_ID_BITS-1:0]                     disp_inst_id,
  input  logic [31:0]                                 disp_inst,
  input  logic [63:0]                                 disp_pc,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]       disp_src_prn,
  input  logic [MAX_OPERANDS-1:0]                     disp_src_rdy,
  input  logic [MAX_OPERANDS-1:0][63:0]               disp_src_data,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]       disp_out_prn,
  input  logic                                        wb_valid,
  input  logic [PRN_BITS-1:0]                         wb_prn,
  input  logic [63:0]                                 wb_data,
  input  logic                                        fu_ready,
  output logic                                        inst_valid,
  output logic [INST_ID_BITS-1:0]                     inst_id,
  output logic [31:0]                                 inst,
  output logic [63:0]                                 pc,
  output logic [MAX_OPERANDS-1:0][63:0]               op,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]       out_prn,
  output logic [$clog2(DEPTH+1)-1:0]                  count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic                                  valid;
    logic [INST_ID_BITS-1:0]               inst_id;
    logic [31:0]                           inst;
    logic [63:0]                           pc;
    logic [MAX_OPERANDS-1:0]               rdy;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn;
    logic [MAX_OPERANDS-1:0][63:0]         data;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn;
  } entry_t;

  entry_t q    [DEPTH];
  entry_t w    [DEPTH+1];
  entry_t nxt  [DEPTH];
  entry_t new_ent;

  logic [CW-1:0]                          cnt_q;
  logic [CW-1:0]                          cnt_nxt;
  logic [CW-1:0]                          wr_idx;
  logic [DEPTH-1:0][MAX_OPERANDS-1:0]     slot_hit;
  logic [MAX_OPERANDS-1:0]                disp_hit;
  logic [DEPTH-1:0]                       ent_rdy;
  logic [DEPTH-1:0]                       pick;
  logic [DEPTH-1:0]                       shift;
  logic                                   any_rdy;
  logic                                   disp_fire;

  // Broadcast matches against stored, still-waiting slots.
  always_comb begin
    slot_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < MAX_OPERANDS; s++) begin
        slot_hit[i][s] = wb_valid && !q[i].rdy[s] && (q[i].prn[s] == wb_prn);
      end
    end
  end

  always_comb begin
    ent_rdy = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef FU_IQ_WAKEUP_BYPASS_EN
      ent_rdy[i] = q[i].valid && (&(q[i].rdy | slot_hit[i]));
`else
      ent_rdy[i] = q[i].valid && (&q[i].rdy);
`endif
    end
  end

  // Oldest-first pick; shift marks the picked index and everything younger.
  always_comb begin
    pick    = '0;
    shift   = '0;
    any_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pick[i]  = ent_rdy[i] && !any_rdy;
      any_rdy  = any_rdy | ent_rdy[i];
      shift[i] = any_rdy;
    end
  end

  assign inst_valid = fu_ready && any_rdy && !flush;
  assign disp_ready = (cnt_q < DEPTH_C) && !flush;
  assign disp_fire  = disp_valid && disp_ready;
  assign count      = cnt_q;

  always_comb begin
    inst_id = '0;
    inst    = '0;
    pc      = '0;
    op      = '0;
    out_prn = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (inst_valid && pick[i]) begin
        inst_id = q[i].inst_id;
        inst    = q[i].inst;
        pc      = q[i].pc;
        out_prn = q[i].out_prn;
        for (int s = 0; s < MAX_OPERANDS; s++) begin
`ifdef FU_IQ_WAKEUP_BYPASS_EN
          op[s] = q[i].rdy[s] ? q[i].data[s] : wb_data;
`else
          op[s] = q[i].data[s];
`endif
        end
      end
    end
  end

  // Incoming instruction also captures a same-cycle broadcast.
  always_comb begin
    disp_hit = '0;
    for (int s = 0; s < MAX_OPERANDS; s++) begin
      disp_hit[s] = wb_valid && !disp_src_rdy[s] && (disp_src_prn[s] == wb_prn);
    end
  end

  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.inst_id = disp_inst_id;
    new_ent.inst    = disp_inst;
    new_ent.pc      = disp_pc;
    new_ent.prn     = disp_src_prn;
    new_ent.out_prn = disp_out_prn;
    for (int s = 0; s < MAX_OPERANDS; s++) begin
      new_ent.rdy[s]  = disp_src_rdy[s] | disp_hit[s];
      new_ent.data[s] = disp_hit[s] ? wb_data : disp_src_data[s];
    end
  end

  // Wakeup applied to every entry; w[DEPTH] is the empty slot shifted in at the top.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w[i] = q[i];
      for (int s = 0; s < MAX_OPERANDS; s++) begin
        if (slot_hit[i][s]) begin
          w[i].rdy[s]  = 1'b1;
          w[i].data[s] = wb_data;
        end
      end
    end
    w[DEPTH] = '0;
  end

  assign wr_idx = cnt_q - CW'(inst_valid);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = (inst_valid && shift[i]) ? w[i+1] : w[i];
      if (disp_fire && (CW'(i) == wr_idx)) begin
        nxt[i] = new_ent;
      end
    end
  end

  assign cnt_nxt = cnt_q + CW'(disp_fire) - CW'(inst_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      cnt_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= nxt[i];
      end
      cnt_q <= cnt_nxt;
    end
  end

endmodule
